fetch_queue_unit: RTL

Parametrised instruction-fetch front end. It owns the program counter and issues sequential requests to a synchronous instruction memory with a fixed one-cycle read latency. Returned instructions are buffered with their PC in a DEPTH-entry queue, which decode drains through a valid/ready handshake. A redirect input flushes the queue and discards in-flight data on a taken branch, and fetching restarts at the new target.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue_unit_if.sv | 32 +++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_queue_unit.sv | 87 ++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    // One queued fetch result: the instruction and the address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Byte distance between consecutive sequential fetches.
    function automatic logic [ADDR_W-1:0] pc_step();
        return ADDR_W'(INSTR_W / 8);
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch unit bus: instruction-memory request/return, redirect and decode handshake.
interface fetch_queue_unit_if #(
    parameter int unsigned DEPTH = 4
);
    import fetch_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [CNT_W-1:0]   occupancy;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, occupancy,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    // Memory / branch unit / decode side.
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, occupancy,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with synchronous clear; head is read combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           pushData,
    input  logic                   pop,
    input  logic                   clear,
    output fetch_entry_t           headData,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;

    // Storage, pointers and count; clear drops everything, push+pop keeps count steady.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[tailPtr] <= pushData;
                tailPtr      <= tailPtr + PTR_W'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign headData = mem[headPtr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC, one-deep in-flight tracking, credit check, redirect.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_queue_unit_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] inflightPc;
    logic              inflight;
    logic              pop;
    logic              push;
    logic              creditOk;
    logic [CNT_W:0]    pending;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      headEntry;
    fetch_entry_t      pushEntry;

    assign pop = (count != '0) & bus.out_ready;

    // Same-cycle pop frees a slot, which is what lets DEPTH=2 stream at full rate.
    assign pending  = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    assign creditOk = pending < (CNT_W + 1)'(DEPTH);

    // Request generation; redirect bypasses the credit check since the queue is flushed.
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.imem_addr = fetchPc;
        if (reset) begin
            if (bus.redirect_valid) begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = bus.redirect_pc;
            end else if (creditOk) begin
                bus.imem_req = 1'b1;
            end
        end
    end

    // PC and in-flight tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPc    <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= '0;
        end else if (bus.redirect_valid) begin
            fetchPc    <= bus.redirect_pc + pc_step();
            inflight   <= 1'b1;
            inflightPc <= bus.redirect_pc;
        end else if (creditOk) begin
            fetchPc    <= fetchPc + pc_step();
            inflight   <= 1'b1;
            inflightPc <= fetchPc;
        end else begin
            inflight <= 1'b0;
        end
    end

    // A return arriving alongside a redirect belongs to the abandoned path.
    assign push      = inflight & ~bus.redirect_valid;
    assign pushEntry = '{pc: inflightPc, instr: bus.imem_rdata};

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushData (pushEntry),
        .pop      (pop),
        .clear    (bus.redirect_valid),
        .headData (headEntry),
        .occupancy(count)
    );

    assign bus.out_valid = count != '0;
    assign bus.out_pc    = headEntry.pc;
    assign bus.out_instr = headEntry.instr;
    assign bus.occupancy = count;

endmodule
